// File: rtl/ls_mem_queue.sv
// In-order load/store queue between the load/store unit and a single-outstanding data cache port.
// Define LS_FORWARD_EN to forward queued word stores directly to younger loads.
module ls_mem_queue #(
    parameter int unsigned DEPTH     = 4,
    parameter int unsigned TAG_WIDTH = 6
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     flush,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic                     in_we,
    input  logic [1:0]               in_size,
    input  logic                     in_unsigned,
    input  logic [31:0]              in_address,
    input  logic [31:0]              in_data,
    input  logic [TAG_WIDTH-1:0]     in_tag,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [31:0]              out_data,
    output logic [TAG_WIDTH-1:0]     out_tag,
    output logic                     cache_req_valid,
    input  logic                     cache_req_ready,
    output logic                     cache_we,
    output logic [31:0]              cache_address,
    output logic [31:0]              cache_wdata,
    output logic [3:0]               cache_be,
    input  logic                     cache_resp_valid,
    input  logic [31:0]              cache_rdata,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StReq  = 2'd1;
    localparam logic [1:0] StWait = 2'd2;

    typedef struct packed {
        logic                 we;
        logic [1:0]           size;
        logic                 uns;
        logic [31:0]          addr;
        logic [31:0]          data;
        logic [TAG_WIDTH-1:0] tag;
    } entry_t;

    function automatic logic [31:0] lane_extract(input logic [31:0] word, input logic [1:0] a,
                                                 input logic [1:0] size, input logic uns);
        logic [31:0] sh;
        logic [31:0] r;
        sh = word;
        r  = word;
        case (size)
            2'b00: begin
                sh = word >> {a, 3'b000};
                r  = uns ? {24'b0, sh[7:0]} : {{24{sh[7]}}, sh[7:0]};
            end
            2'b01: begin
                sh = word >> {a[1], 4'b0000};
                r  = uns ? {16'b0, sh[15:0]} : {{16{sh[15]}}, sh[15:0]};
            end
            default: r = word;
        endcase
        return r;
    endfunction

    function automatic logic [3:0] byte_en(input logic [1:0] a, input logic [1:0] size);
        case (size)
            2'b00:   return 4'b0001 << a;
            2'b01:   return 4'b0011 << {a[1], 1'b0};
            default: return 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] lane_wdata(input logic [31:0] d, input logic [1:0] size);
        case (size)
            2'b00:   return {4{d[7:0]}};
            2'b01:   return {2{d[15:0]}};
            default: return d;
        endcase
    endfunction

    entry_t               ent_q [DEPTH];
    entry_t               ent_d [DEPTH];
    logic [AW-1:0]        rd_q, rd_d, wr_q, wr_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    entry_t               new_ent, src;

    logic [1:0]           state_q, state_d;
    logic                 req_valid_q, req_we_q, req_uns_q, req_inq_q, discard_q;
    logic [31:0]          req_addr_q, req_wdata_q;
    logic [3:0]           req_be_q;
    logic [1:0]           req_size_q, req_lo_q;
    logic [TAG_WIDTH-1:0] req_tag_q;

    logic                 out_valid_q, out_is_load_q;
    logic [31:0]          out_data_q;
    logic [TAG_WIDTH-1:0] out_tag_q;

    logic full, accept, enq, fwd, issue, req_acc, pop, resp_take, resp_write;
    logic [31:0] fwd_data;

    assign full       = cnt_q == CW'(DEPTH);
    assign in_ready   = !full && !cache_resp_valid && (!out_valid_q || out_ready);
    assign accept     = in_valid && in_ready;
    assign enq        = accept && !fwd;
    assign req_acc    = (state_q == StReq) && cache_req_ready;
    // A flushed load still sitting in REQ has already left the queue, so its acceptance pops nothing.
    assign pop        = req_acc && req_inq_q;
    assign resp_take  = (state_q == StWait) && cache_resp_valid;
    assign resp_write = resp_take && !discard_q && !flush;

    always_comb begin
        new_ent.we   = in_we;
        new_ent.size = in_size;
        new_ent.uns  = in_unsigned;
        new_ent.addr = in_address;
        new_ent.data = in_data;
        new_ent.tag  = in_tag;
    end

`ifdef LS_FORWARD_EN
    logic          fwd_hit, fwd_word;
    logic [AW-1:0] fidx;

    // Scan oldest to youngest so the last hit is the youngest matching store.
    always_comb begin
        fwd_hit  = 1'b0;
        fwd_word = 1'b0;
        fwd_data = '0;
        fidx     = '0;
        for (int i = 0; i < int'(DEPTH); i++) begin
            fidx = rd_q + i[AW-1:0];
            if (i < int'(cnt_q) && ent_q[fidx].we &&
                ent_q[fidx].addr[31:2] == in_address[31:2]) begin
                fwd_hit  = 1'b1;
                fwd_word = ent_q[fidx].size == 2'b10;
                fwd_data = ent_q[fidx].data;
            end
        end
    end

    assign fwd = !in_we && fwd_hit && fwd_word;
`else
    assign fwd      = 1'b0;
    assign fwd_data = '0;
`endif

    logic [CW-1:0] k;
    logic [AW-1:0] cidx;

    always_comb begin
        ent_d = ent_q;
        rd_d  = rd_q;
        wr_d  = wr_q;
        cnt_d = cnt_q;
        k     = '0;
        cidx  = '0;
        if (flush) begin
            // Compact surviving stores to the bottom of the array, oldest first.
            for (int i = 0; i < int'(DEPTH); i++) begin
                cidx = rd_q + i[AW-1:0];
                if (i < int'(cnt_q) && !(pop && i == 0) && ent_q[cidx].we) begin
                    ent_d[k[AW-1:0]] = ent_q[cidx];
                    k = k + CW'(1);
                end
            end
            rd_d  = '0;
            wr_d  = k[AW-1:0];
            cnt_d = k;
        end else if (pop) begin
            rd_d  = rd_q + AW'(1);
            cnt_d = cnt_q - CW'(1);
        end
        if (enq) begin
            ent_d[wr_d] = new_ent;
            wr_d  = wr_d + AW'(1);
            cnt_d = cnt_d + CW'(1);
        end
    end

    // With an empty queue the incoming request is issued directly, saving a cycle.
    assign src = (cnt_q != '0) ? ent_q[rd_q] : new_ent;

    always_comb begin
        state_d = state_q;
        issue   = 1'b0;
        case (state_q)
            StIdle: begin
                if (!flush && (cnt_q != '0 || enq)) begin
                    issue   = 1'b1;
                    state_d = StReq;
                end
            end
            StReq:   if (cache_req_ready) state_d = req_we_q ? StIdle : StWait;
            StWait:  if (cache_resp_valid) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < int'(DEPTH); i++) ent_q[i] <= '0;
            rd_q  <= '0;
            wr_q  <= '0;
            cnt_q <= '0;
        end else begin
            ent_q <= ent_d;
            rd_q  <= rd_d;
            wr_q  <= wr_d;
            cnt_q <= cnt_d;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= StIdle;
            req_valid_q <= 1'b0;
            req_we_q    <= 1'b0;
            req_addr_q  <= '0;
            req_wdata_q <= '0;
            req_be_q    <= '0;
            req_size_q  <= '0;
            req_lo_q    <= '0;
            req_uns_q   <= 1'b0;
            req_tag_q   <= '0;
            req_inq_q   <= 1'b0;
            discard_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            if (issue) begin
                req_valid_q <= 1'b1;
                req_we_q    <= src.we;
                req_addr_q  <= {src.addr[31:2], 2'b00};
                req_wdata_q <= src.we ? lane_wdata(src.data, src.size) : 32'h0;
                req_be_q    <= byte_en(src.addr[1:0], src.size);
                req_size_q  <= src.size;
                req_lo_q    <= src.addr[1:0];
                req_uns_q   <= src.uns;
                req_tag_q   <= src.tag;
                req_inq_q   <= 1'b1;
            end else begin
                if (req_acc) req_valid_q <= 1'b0;
                if (flush && state_q == StReq && !req_we_q) req_inq_q <= 1'b0;
            end
            if (resp_take) begin
                discard_q <= 1'b0;
            end else if (flush && ((state_q == StReq && !req_we_q) || state_q == StWait)) begin
                discard_q <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_valid_q   <= 1'b0;
            out_is_load_q <= 1'b0;
            out_data_q    <= '0;
            out_tag_q     <= '0;
        end else if (resp_write) begin
            out_valid_q   <= 1'b1;
            out_is_load_q <= 1'b1;
            out_data_q    <= lane_extract(cache_rdata, req_lo_q, req_size_q, req_uns_q);
            out_tag_q     <= req_tag_q;
        end else if (accept && (in_we || fwd)) begin
            out_valid_q   <= 1'b1;
            out_is_load_q <= !in_we;
            out_data_q    <= in_we ? 32'h0 :
                             lane_extract(fwd_data, in_address[1:0], in_size, in_unsigned);
            out_tag_q     <= in_tag;
        end else if ((out_valid_q && out_ready) || (flush && out_is_load_q)) begin
            out_valid_q   <= 1'b0;
        end
    end

    assign out_valid       = out_valid_q;
    assign out_data        = out_data_q;
    assign out_tag         = out_tag_q;
    assign cache_req_valid = req_valid_q;
    assign cache_we        = req_we_q;
    assign cache_address   = req_addr_q;
    assign cache_wdata     = req_wdata_q;
    assign cache_be        = req_be_q;
    assign count           = cnt_q;

endmodule

// File: tb/tb_ls_mem_queue.sv
// Directed scoreboard bench for ls_mem_queue; honours LS_FORWARD_EN when defined.
module tb_ls_mem_queue;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        in_we = 1'b0;
    logic [1:0]  in_size = 2'b00;
    logic        in_unsigned = 1'b0;
    logic [31:0] in_address = 32'h0;
    logic [31:0] in_data = 32'h0;
    logic [5:0]  in_tag = 6'h0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_data;
    logic [5:0]  out_tag;
    logic        cache_req_valid;
    logic        cache_req_ready = 1'b1;
    logic        cache_we;
    logic [31:0] cache_address;
    logic [31:0] cache_wdata;
    logic [3:0]  cache_be;
    logic        cache_resp_valid;
    logic [31:0] cache_rdata;
    logic [2:0]  count;

    ls_mem_queue #(.DEPTH(4), .TAG_WIDTH(6)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_we(in_we), .in_size(in_size),
        .in_unsigned(in_unsigned), .in_address(in_address), .in_data(in_data), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_tag(out_tag),
        .cache_req_valid(cache_req_valid), .cache_req_ready(cache_req_ready),
        .cache_we(cache_we), .cache_address(cache_address), .cache_wdata(cache_wdata),
        .cache_be(cache_be), .cache_resp_valid(cache_resp_valid), .cache_rdata(cache_rdata),
        .count(count)
    );

    always #5 clk = ~clk;

    typedef struct packed { logic [5:0] tag; logic [31:0] data; } cpl_t;
    typedef struct packed { logic we; logic [31:0] addr; logic [3:0] be; logic [31:0] wdata; } req_t;

    cpl_t exp_cpl[$];
    req_t exp_req[$];
    int   n_chk = 0;
    int   n_fail = 0;

    logic [31:0] rd_word = 32'h0;
    logic        resp_en = 1'b1;
    logic        force_resp = 1'b0;
    logic        model_resp = 1'b0;
    logic        pend = 1'b0;

    assign cache_resp_valid = model_resp || force_resp;
    assign cache_rdata      = rd_word;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] expv);
        n_chk++;
        assert (got === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", name, got, expv);
        end
    endtask

    task automatic push_req(input logic we, input logic [31:0] addr, input logic [3:0] be,
                            input logic [31:0] wdata);
        req_t r;
        r.we = we; r.addr = addr; r.be = be; r.wdata = wdata;
        exp_req.push_back(r);
    endtask

    task automatic push_cpl(input logic [5:0] tag, input logic [31:0] data);
        cpl_t c;
        c.tag = tag; c.data = data;
        exp_cpl.push_back(c);
    endtask

    // Cache model: a read answers one cycle after its acceptance edge.
    always @(negedge clk) begin
        model_resp = pend;
        pend = reset && resp_en && cache_req_valid && cache_req_ready && !cache_we;
    end

    logic        have_prev = 1'b0;
    logic [31:0] prev_addr, prev_wdata;
    logic [5:0]  prev_ctl;

    always @(negedge clk) begin
        if (!reset) begin
            have_prev = 1'b0;
        end else begin
            if (have_prev) begin
                chk("req_stable_ctl", {26'b0, cache_req_valid, cache_we, cache_be}, {26'b0, prev_ctl});
                chk("req_stable_addr", cache_address, prev_addr);
                chk("req_stable_wdata", cache_wdata, prev_wdata);
            end
            if (out_valid && out_ready) begin
                chk("cpl_expected", 32'(exp_cpl.size() != 0), 32'd1);
                if (exp_cpl.size() != 0) begin
                    cpl_t c;
                    c = exp_cpl.pop_front();
                    chk("cpl_tag", 32'(out_tag), 32'(c.tag));
                    chk("cpl_data", out_data, c.data);
                end
            end
            if (cache_req_valid && cache_req_ready) begin
                chk("req_expected", 32'(exp_req.size() != 0), 32'd1);
                if (exp_req.size() != 0) begin
                    req_t r;
                    r = exp_req.pop_front();
                    chk("req_we", 32'(cache_we), 32'(r.we));
                    chk("req_addr", cache_address, r.addr);
                    if (r.we) begin
                        chk("req_be", 32'(cache_be), 32'(r.be));
                        chk("req_wdata", cache_wdata, r.wdata);
                    end
                end
            end
            have_prev  = cache_req_valid && !cache_req_ready;
            prev_ctl   = {cache_req_valid, cache_we, cache_be};
            prev_addr  = cache_address;
            prev_wdata = cache_wdata;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Called just after a rising edge; returns just after the accepting edge.
    task automatic send(input logic we, input logic [1:0] size, input logic uns,
                        input logic [31:0] addr, input logic [31:0] data, input logic [5:0] tag);
        int n = 0;
        in_we = we; in_size = size; in_unsigned = uns;
        in_address = addr; in_data = data; in_tag = tag; in_valid = 1'b1;
        @(negedge clk); #1;
        while (!in_ready && n < 50) begin
            @(negedge clk); #1;
            n++;
        end
        chk("send_ready", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (n < 200 && !(exp_cpl.size() == 0 && exp_req.size() == 0 && count == 0 && !out_valid)) begin
            tick(1);
            n++;
        end
        tick(2);
        chk("drain", 32'(n < 200), 32'd1);
    endtask

    initial begin
        #2 reset = 1'b0;
        #10;
        chk("rst_count", 32'(count), 0);
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_out_tag", 32'(out_tag), 0);
        chk("rst_req_valid", 32'(cache_req_valid), 0);
        chk("rst_cache_we", 32'(cache_we), 0);
        chk("rst_cache_addr", cache_address, 0);
        chk("rst_cache_wdata", cache_wdata, 0);
        chk("rst_cache_be", 32'(cache_be), 0);
        @(posedge clk); #1;
        reset = 1'b1;
        tick(1);

        // Word store: completes the cycle after acceptance, request issued at once.
        push_req(1'b1, 32'h100, 4'hf, 32'hDEADBEEF);
        push_cpl(6'd3, 32'h0);
        send(1'b1, 2'b10, 1'b0, 32'h100, 32'hDEADBEEF, 6'd3);
        chk("store_lat_valid", 32'(out_valid), 1);
        chk("store_lat_tag", 32'(out_tag), 3);
        chk("store_req_lat", 32'(cache_req_valid), 1);
        drain();

        // Signed byte load with latency checks.
        rd_word = 32'h80FF0000;
        push_req(1'b0, 32'h100, 4'h0, 32'h0);
        push_cpl(6'd7, 32'hFFFFFF80);
        send(1'b0, 2'b00, 1'b0, 32'h103, 32'h0, 6'd7);
        chk("load_req_lat", 32'(cache_req_valid), 1);
        tick(1);
        chk("load_early", 32'(out_valid), 0);
        tick(1);
        chk("load_lat", 32'(out_valid), 1);
        drain();

        push_req(1'b0, 32'h100, 4'h0, 32'h0);
        push_cpl(6'd8, 32'h00000080);
        send(1'b0, 2'b00, 1'b1, 32'h103, 32'h0, 6'd8);
        push_req(1'b0, 32'h100, 4'h0, 32'h0);
        push_cpl(6'd9, 32'hFFFF80FF);
        send(1'b0, 2'b01, 1'b0, 32'h102, 32'h0, 6'd9);
        drain();
        push_req(1'b0, 32'h100, 4'h0, 32'h0);
        push_cpl(6'd10, 32'h80FF0000);
        send(1'b0, 2'b10, 1'b0, 32'h103, 32'h0, 6'd10);
        drain();
        rd_word = 32'h1234ABCD;
        push_req(1'b0, 32'h100, 4'h0, 32'h0);
        push_cpl(6'd11, 32'h0000ABCD);
        send(1'b0, 2'b01, 1'b1, 32'h101, 32'h0, 6'd11);
        drain();
        push_req(1'b0, 32'h100, 4'h0, 32'h0);
        push_cpl(6'd12, 32'hFFFFFFAB);
        send(1'b0, 2'b00, 1'b0, 32'h101, 32'h0, 6'd12);
        drain();

        // Narrow stores: lane enables and replicated data.
        push_req(1'b1, 32'h104, 4'b1000, 32'hA5A5A5A5);
        push_cpl(6'd13, 32'h0);
        send(1'b1, 2'b00, 1'b0, 32'h107, 32'h000000A5, 6'd13);
        push_req(1'b1, 32'h108, 4'b1100, 32'hBEEFBEEF);
        push_cpl(6'd14, 32'h0);
        send(1'b1, 2'b01, 1'b0, 32'h10B, 32'h1234BEEF, 6'd14);
        drain();

        // Fill the queue with the cache stalled, then release; second burst wraps.
        cache_req_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            push_req(1'b1, 32'h300 + 32'(4 * i), 4'hf, 32'h1000 + 32'(i));
            push_cpl(6'(16 + i), 32'h0);
            send(1'b1, 2'b10, 1'b0, 32'h300 + 32'(4 * i), 32'h1000 + 32'(i), 6'(16 + i));
        end
        chk("full_count", 32'(count), 4);
        chk("full_in_ready", 32'(in_ready), 0);
        tick(3);
        cache_req_ready = 1'b1;
        drain();
        chk("empty_count", 32'(count), 0);
        for (int i = 0; i < 3; i++) begin
            push_req(1'b1, 32'h380 + 32'(4 * i), 4'hf, 32'h2000 + 32'(i));
            push_cpl(6'(24 + i), 32'h0);
            send(1'b1, 2'b10, 1'b0, 32'h380 + 32'(4 * i), 32'h2000 + 32'(i), 6'(24 + i));
        end
        drain();

        // Store-to-load forwarding (or a normal cache read without it).
        cache_req_ready = 1'b0;
        rd_word = 32'h12345678;
        push_req(1'b1, 32'h200, 4'hf, 32'h12345678);
        push_cpl(6'd20, 32'h0);
        send(1'b1, 2'b10, 1'b0, 32'h200, 32'h12345678, 6'd20);
`ifdef LS_FORWARD_EN
        push_cpl(6'd21, 32'h00001234);
        send(1'b0, 2'b01, 1'b1, 32'h202, 32'h0, 6'd21);
        chk("fwd_valid", 32'(out_valid), 1);
        chk("fwd_data", out_data, 32'h00001234);
        chk("fwd_count", 32'(count), 1);
`else
        push_req(1'b0, 32'h200, 4'h0, 32'h0);
        push_cpl(6'd21, 32'h00001234);
        send(1'b0, 2'b01, 1'b1, 32'h202, 32'h0, 6'd21);
        chk("nofwd_count", 32'(count), 2);
`endif
        cache_req_ready = 1'b1;
        drain();

        // Flush drops the queued load, keeps both stores in order.
        cache_req_ready = 1'b0;
        push_req(1'b1, 32'h400, 4'hf, 32'hAAAA0000);
        push_cpl(6'd30, 32'h0);
        send(1'b1, 2'b10, 1'b0, 32'h400, 32'hAAAA0000, 6'd30);
        send(1'b0, 2'b10, 1'b0, 32'h404, 32'h0, 6'd5);
        push_req(1'b1, 32'h408, 4'hf, 32'h0000CCCC);
        push_cpl(6'd31, 32'h0);
        send(1'b1, 2'b10, 1'b0, 32'h408, 32'h0000CCCC, 6'd31);
        chk("preflush_count", 32'(count), 3);
        flush = 1'b1;
        tick(1);
        flush = 1'b0;
        chk("postflush_count", 32'(count), 2);
        cache_req_ready = 1'b1;
        drain();

        // Flush while a load waits for data: its response is discarded.
        resp_en = 1'b0;
        push_req(1'b0, 32'h500, 4'h0, 32'h0);
        send(1'b0, 2'b10, 1'b0, 32'h500, 32'h0, 6'd40);
        tick(3);
        flush = 1'b1;
        tick(1);
        flush = 1'b0;
        tick(2);
        force_resp = 1'b1;
        tick(1);
        force_resp = 1'b0;
        tick(3);
        chk("wait_flush_no_cpl", 32'(out_valid), 0);
        resp_en = 1'b1;
        rd_word = 32'h55667788;
        push_req(1'b0, 32'h504, 4'h0, 32'h0);
        push_cpl(6'd41, 32'h55667788);
        send(1'b0, 2'b10, 1'b0, 32'h504, 32'h0, 6'd41);
        drain();

        // Asynchronous reset while in WAIT with a completion held.
        resp_en = 1'b0;
        push_req(1'b0, 32'h600, 4'h0, 32'h0);
        send(1'b0, 2'b10, 1'b0, 32'h600, 32'h0, 6'd51);
        tick(3);
        out_ready = 1'b0;
        send(1'b1, 2'b10, 1'b0, 32'h604, 32'h77, 6'd50);
        chk("pre_reset_valid", 32'(out_valid), 1);
        #3 reset = 1'b0;
        #1;
        chk("areset_out_valid", 32'(out_valid), 0);
        chk("areset_out_tag", 32'(out_tag), 0);
        chk("areset_out_data", out_data, 0);
        chk("areset_count", 32'(count), 0);
        chk("areset_req_valid", 32'(cache_req_valid), 0);
        chk("areset_cache_we", 32'(cache_we), 0);
        chk("areset_cache_addr", cache_address, 0);
        chk("areset_cache_be", 32'(cache_be), 0);
        chk("areset_cache_wdata", cache_wdata, 0);
        @(posedge clk); #1;
        reset = 1'b1;
        out_ready = 1'b1;
        force_resp = 1'b1;
        tick(1);
        force_resp = 1'b0;
        tick(3);
        chk("late_resp_no_cpl", 32'(out_valid), 0);
        resp_en = 1'b1;

        chk("cpl_left", 32'(exp_cpl.size()), 0);
        chk("req_left", 32'(exp_req.size()), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end
endmodule
